// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and load/store share one
// memory port with at most one transaction in flight and bounded fetch starvation.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_r;
    logic                  owner_ls_r;
    logic                  store_r;
    logic [STREAK_W-1:0]   streak_r;
    logic [DATA_W-1:0]     if_rdata_r;
    logic [DATA_W-1:0]     ls_rdata_r;

    logic                  starve_s;
    logic                  if_sel_s;
    logic                  ls_sel_s;
    logic                  deliver_s;

    // Owner selection, response detection and the pass-through response outputs
    always_comb begin
        if_sel_s  = 1'b0;
        ls_sel_s  = 1'b0;
        deliver_s = 1'b0;
        starve_s  = (streak_r == STREAK_W'(STARVE_LIMIT));

        if (!rst && (state_r == IDLE)) begin
            if (if_req && (starve_s || !ls_req)) begin
                if_sel_s = 1'b1;
            end else if (ls_req) begin
                ls_sel_s = 1'b1;
            end else begin
                if_sel_s = 1'b0;
                ls_sel_s = 1'b0;
            end
        end else begin
            if_sel_s = 1'b0;
            ls_sel_s = 1'b0;
        end

        // A response accepted in REQ only counts when the request is granted alongside it
        if (!rst && mem_rvalid) begin
            case (state_r)
                RESP:    deliver_s = 1'b1;
                REQ:     deliver_s = mem_gnt;
                default: deliver_s = 1'b0;
            endcase
        end else begin
            deliver_s = 1'b0;
        end

        if_gnt    = if_sel_s;
        ls_gnt    = ls_sel_s;
        if_rvalid = deliver_s & ~owner_ls_r;
        ls_rvalid = deliver_s & owner_ls_r;

        if (deliver_s && !owner_ls_r) begin
            if_rdata = mem_rdata;
        end else begin
            if_rdata = if_rdata_r;
        end

        if (deliver_s && owner_ls_r) begin
            if (store_r) begin
                ls_rdata = {DATA_W{1'b0}};
            end else begin
                ls_rdata = mem_rdata;
            end
        end else begin
            ls_rdata = ls_rdata_r;
        end
    end

    // Transaction FSM, registered memory request, starvation streak and held read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_ls_r <= 1'b0;
            store_r    <= 1'b0;
            streak_r   <= {STREAK_W{1'b0}};
            if_rdata_r <= {DATA_W{1'b0}};
            ls_rdata_r <= {DATA_W{1'b0}};
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= {BE_W{1'b0}};
            mem_addr   <= {ADDR_W{1'b0}};
            mem_wdata  <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (if_sel_s) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= {BE_W{1'b1}};
                        mem_addr   <= if_addr;
                        mem_wdata  <= {DATA_W{1'b0}};
                        owner_ls_r <= 1'b0;
                        store_r    <= 1'b0;
                        state_r    <= REQ;
                    end else if (ls_sel_s) begin
                        mem_req    <= 1'b1;
                        mem_we     <= ls_we;
                        mem_be     <= ls_we ? ls_be : {BE_W{1'b1}};
                        mem_addr   <= ls_addr;
                        mem_wdata  <= ls_wdata;
                        owner_ls_r <= 1'b1;
                        store_r    <= ls_we;
                        state_r    <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= deliver_s ? IDLE : RESP;
                    end else begin
                        state_r <= REQ;
                    end
                end
                RESP: begin
                    state_r <= deliver_s ? IDLE : RESP;
                end
                default: begin
                    mem_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase

            if (!if_req || if_sel_s) begin
                streak_r <= {STREAK_W{1'b0}};
            end else if (ls_sel_s && !starve_s) begin
                streak_r <= streak_r + STREAK_W'(1);
            end

            if (deliver_s && !owner_ls_r) begin
                if_rdata_r <= mem_rdata;
            end
            if (deliver_s && owner_ls_r) begin
                ls_rdata_r <= store_r ? {DATA_W{1'b0}} : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // reference model: one transaction in flight, issued until accepted, then awaiting data
    bit          busy = 1'b0, accepted = 1'b0, after_rst = 1'b0;
    int          streak = 0;
    bit          t_ls, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] last_if = 32'h0, last_ls = 32'h0;
    bit          e_if_gnt, e_ls_gnt, e_dlv;
    bit          if_taken = 1'b0, ls_taken = 1'b0;
    int          resp_wait = 0;
    bit          gnt_log[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        #2;
        e_if_gnt = 1'b0;
        e_ls_gnt = 1'b0;
        e_dlv    = 1'b0;
        if (!rst && !busy) begin
            if (if_req && (!ls_req || streak == STARVE)) e_if_gnt = 1'b1;
            else if (ls_req) e_ls_gnt = 1'b1;
        end
        if (!rst && busy && mem_rvalid && (accepted || mem_gnt)) e_dlv = 1'b1;

        check("m_if_gnt", 32'(if_gnt), 32'(e_if_gnt));
        check("m_ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
        if (rst) begin
            check("m_if_rvalid_rst", 32'(if_rvalid), 32'd0);
            check("m_ls_rvalid_rst", 32'(ls_rvalid), 32'd0);
        end else begin
            check("m_mem_req", 32'(mem_req), 32'(busy && !accepted));
            if (busy && !accepted) begin
                check("m_mem_addr", mem_addr, t_addr);
                check("m_mem_we", 32'(mem_we), 32'(t_we));
                check("m_mem_be", 32'(mem_be), 32'(t_be));
                if (t_we) check("m_mem_wdata", mem_wdata, t_wdata);
            end
            if (after_rst) begin
                check("m_rst_addr", mem_addr, 32'd0);
                check("m_rst_wdata", mem_wdata, 32'd0);
                check("m_rst_be", 32'(mem_be), 32'd0);
                check("m_rst_we", 32'(mem_we), 32'd0);
            end
            if (e_dlv && !t_ls) last_if = mem_rdata;
            if (e_dlv && t_ls)  last_ls = t_we ? 32'd0 : mem_rdata;
            check("m_if_rvalid", 32'(if_rvalid), 32'(e_dlv && !t_ls));
            check("m_ls_rvalid", 32'(ls_rvalid), 32'(e_dlv && t_ls));
            check("m_if_rdata", if_rdata, last_if);
            check("m_ls_rdata", ls_rdata, last_ls);
            if (if_gnt || ls_gnt) gnt_log.push_back(if_gnt);
        end

        if (rst) begin
            busy = 1'b0; accepted = 1'b0; streak = 0;
            last_if = 32'h0; last_ls = 32'h0; after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (e_dlv) busy = 1'b0;
            else if (busy && mem_gnt) accepted = 1'b1;
            if (e_if_gnt || e_ls_gnt) begin
                busy     = 1'b1;
                accepted = 1'b0;
                t_ls     = e_ls_gnt;
                t_we     = e_ls_gnt && ls_we;
                t_be     = (e_ls_gnt && ls_we) ? ls_be : 4'hF;
                t_addr   = e_ls_gnt ? ls_addr : if_addr;
                t_wdata  = ls_wdata;
            end
            if (!if_req || e_if_gnt) streak = 0;
            else if (e_ls_gnt && streak < STARVE) streak++;
            if (e_if_gnt) if_taken = 1'b1;
            if (e_ls_gnt) ls_taken = 1'b1;
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic drive_mem();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (busy && !accepted) begin
            if ($urandom_range(0, 2) != 0) begin
                mem_gnt    = 1'b1;
                resp_wait  = $urandom_range(0, 2);
                mem_rvalid = (resp_wait == 0);
            end else begin
                mem_rvalid = ($urandom_range(0, 7) == 0);
            end
        end else if (busy) begin
            if (resp_wait <= 1) mem_rvalid = 1'b1;
            else resp_wait--;
        end else begin
            mem_rvalid = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic drive_req();
        if (if_taken) begin if_taken = 1'b0; if_req = 1'b0; end
        if (ls_taken) begin ls_taken = 1'b0; ls_req = 1'b0; end
        if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req = 1'b1; if_addr = $urandom;
        end
        if (!ls_req && $urandom_range(0, 2) != 0) begin
            ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_be = 4'($urandom);
            ls_addr = $urandom; ls_wdata = $urandom;
        end
    endtask

    logic [9:0] exp_order;

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #3;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);

        // single fetch, zero-wait memory
        @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
        #3; check("f_if_gnt", 32'(if_gnt), 32'd1); check("f_ls_gnt", 32'(ls_gnt), 32'd0);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1;
        #3; check("f_mem_req", 32'(mem_req), 32'd1); check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_be", 32'(mem_be), 32'hF);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        #3; check("f_if_rvalid", 32'(if_rvalid), 32'd1); check("f_if_rdata", if_rdata, 32'h00500093);
        @(negedge clk); mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #3; check("f_if_rvalid_off", 32'(if_rvalid), 32'd0); check("f_if_rdata_hold", if_rdata, 32'h00500093);

        // simultaneous fetch and load: load first
        @(negedge clk); if_req = 1'b1; if_addr = 32'h104; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
        #3; check("p_ls_gnt", 32'(ls_gnt), 32'd1); check("p_if_gnt", 32'(if_gnt), 32'd0);
        @(negedge clk); ls_req = 1'b0; mem_gnt = 1'b1;
        #3; check("p_mem_addr", mem_addr, 32'h2000); check("p_if_gnt_busy", 32'(if_gnt), 32'd0);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        #3; check("p_ls_rvalid", 32'(ls_rvalid), 32'd1); check("p_ls_rdata", ls_rdata, 32'h11223344);
        check("p_if_rvalid", 32'(if_rvalid), 32'd0);
        @(negedge clk); mem_rvalid = 1'b0;
        #3; check("p_if_gnt_after", 32'(if_gnt), 32'd1);
        // grant and response in the same cycle
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        #3; check("s_if_rvalid", 32'(if_rvalid), 32'd1); check("s_if_rdata", if_rdata, 32'hCAFE0001);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; if_req = 1'b1; if_addr = 32'h108;
        #3; check("s_no_dup", 32'(if_rvalid), 32'd0); check("s_idle_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h3;
        #3; check("s2_if_rvalid", 32'(if_rvalid), 32'd1);
        @(negedge clk); idle_inputs();

        // starvation bound under continuous traffic
        do_reset();
        gnt_log.delete();
        if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h800;
        repeat (150) begin @(negedge clk); drive_mem(); end
        exp_order = 10'b1000010000;
        check("order_count", 32'(gnt_log.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++)
            if (i < gnt_log.size()) check("order", 32'(gnt_log[i]), 32'(exp_order[i]));

        // byte store with delayed memory grant
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b1000; ls_addr = 32'h3003; ls_wdata = 32'hAB000000;
        #3; check("sb_ls_gnt", 32'(ls_gnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); ls_req = 1'b0; mem_gnt = (k == 3);
            #3;
            check("sb_mem_req", 32'(mem_req), 32'd1);
            check("sb_mem_addr", mem_addr, 32'h3003);
            check("sb_mem_be", 32'(mem_be), 32'h8);
            check("sb_mem_wdata", mem_wdata, 32'hAB000000);
            check("sb_mem_we", 32'(mem_we), 32'd1);
        end
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #3; check("sb_ls_rvalid", 32'(ls_rvalid), 32'd1); check("sb_ls_rdata", ls_rdata, 32'd0);
        @(negedge clk); idle_inputs();

        // reset while waiting for data, then a stray response
        @(negedge clk); if_req = 1'b1; if_addr = 32'h200;
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; rst = 1'b1;
        #3; check("r_if_gnt", 32'(if_gnt), 32'd0);
        @(negedge clk); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #3; check("r_mem_req", 32'(mem_req), 32'd0); check("r_if_rvalid", 32'(if_rvalid), 32'd0);
        check("r_if_rdata", if_rdata, 32'd0);
        @(negedge clk); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h204;
        #3; check("r_if_gnt_after", 32'(if_gnt), 32'd1);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        #3; check("r_if_rvalid_after", 32'(if_rvalid), 32'd1); check("r_if_rdata_after", if_rdata, 32'h0BADF00D);
        @(negedge clk); idle_inputs();

        // randomized traffic with occasional resets
        if_taken = 1'b0; ls_taken = 1'b0;
        repeat (2500) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            drive_req();
            drive_mem();
        end
        @(negedge clk); rst = 1'b0; idle_inputs();
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
